wb_fpga_bus_arbiter: RTL
========================

Name: wb_fpga_bus_arbiter

Overview:
Shares the single FPGA-side Wishbone client bus between two masters. Master 0 is the AHB-to-FPGA bridge; master 1 is an internal fabric master, such as a DMA or sensor sequencer. Arbitration is round-robin, and the granted master holds the bus for its whole CYC tenure. A per-access watchdog returns a default acknowledge and data when no slave responds, so neither master can hang the bus.

Parameters:
ADDRWIDTH, 17, Wishbone address width.
DATAWIDTH, 32, Wishbone data width.
TIMEOUT_CYCLES, 15, cycles from STB assertion to watchdog ack (legal range 2..2^CNTR_WIDTH-1).
CNTR_WIDTH, 4, watchdog counter width.
DEF_RD_VALUE, 32'hDEF_FAB_AC, read data returned on watchdog ack.

Ports:
WBs_CLK_i  in  1  bus clock.
WBs_RSTn_i  in  1  asynchronous active-low reset.
M0_CYC_i / M1_CYC_i  in  1  master cycle request.
M0_STB_i / M1_STB_i  in  1  master strobe.
M0_WE_i / M1_WE_i  in  1  write enable.
M0_ADR_i / M1_ADR_i  in  ADDRWIDTH  address.
M0_DAT_i / M1_DAT_i  in  DATAWIDTH  write data.
M0_ACK_o / M1_ACK_o  out  1  acknowledge to master.
M0_DAT_o / M1_DAT_o  out  DATAWIDTH  read data to master.
WBs_CYC_o, WBs_STB_o, WBs_WE_o  out  1  to slave bus.
WBs_ADR_o  out  ADDRWIDTH  to slave bus.
WBs_DAT_o  out  DATAWIDTH  to slave bus.
WBs_ACK_i  in  1  OR of all slave acks.
WBs_DAT_i  in  DATAWIDTH  muxed slave read data.
Grant_o  out  2  one-hot current grant (00 = none).
Timeout_o  out  1  one-cycle pulse when the watchdog acks.
Timeout_Cnt_o  out  8  saturating count of watchdog events.

Behaviour:
- Reset (async, WBs_RSTn_i low):
  - FSM=IDLE; Grant_o=00; all ACK/CYC/STB outputs 0; Timeout_o=0; Timeout_Cnt_o=0.
  - Last-grant pointer=M1, so M0 wins the first tie.
- Reset asserted mid-transfer aborts the transfer immediately. No ack is issued and the slave bus drops CYC/STB asynchronously.
- FSM states: IDLE, OWN0, OWN1, WDOG.
- IDLE:
  - Request set sampled at the clock edge.
  - Only M0_CYC_i high -> OWN0. Only M1_CYC_i high -> OWN1.
  - Both high -> grant the master that is not the last-grant pointer. The pointer updates on grant.
  - No request -> stay in IDLE.
  - Grant latency: 1 cycle from CYC to Grant_o.
- OWNx:
  - Slave outputs are a combinational mux of master x inputs; WBs_CYC_o=Mx_CYC_i, WBs_STB_o=Mx_STB_i.
  - Mx_ACK_o=WBs_ACK_i and Mx_DAT_o=WBs_DAT_i, both combinational.
  - The non-granted master sees ACK=0 and DAT=0.
  - Mx_CYC_i low at a clock edge -> IDLE. A minimum of 1 idle cycle separates tenures.
  - A master may issue multiple STB phases within one CYC without re-arbitration.
- Watchdog counter:
  - Loaded with TIMEOUT_CYCLES whenever STB is low or an ack occurs.
  - Decrements each cycle while granted STB is high and WBs_ACK_i is low.
  - Counter==1 with no ack -> WDOG next cycle.
- WDOG (exactly 1 cycle):
  - WBs_STB_o forced 0 and WBs_CYC_o held.
  - Mx_ACK_o=1 and Mx_DAT_o=DEF_RD_VALUE.
  - Timeout_o=1 and Timeout_Cnt_o increments, saturating at 8'hFF.
  - Next state returns to OWNx.
- Simultaneous events:
  - Slave ACK in the same cycle the counter reaches 1: slave ack wins, no WDOG.
  - A late slave ACK arriving during WDOG is ignored, not forwarded.
  - Granted master drops CYC while in WDOG: the ack is still given, then IDLE.
- Writes that time out are acked with no data effect.
- Grant_o reflects the registered FSM state.

Optional Feature:
- Macro WB_ARB_WATCHDOG_EN.
- Defined: watchdog, WDOG state, Timeout_o and Timeout_Cnt_o are present as described above.
- Undefined: the watchdog logic is removed, and an unacknowledged access holds the grant indefinitly. Timeout_o is tied to 0 and Timeout_Cnt_o to 8'h00.

Test Plan:
- M0 read of addr 0x00010, slave acks 2 cycles after STB with 0x12345678 -> Grant_o=01 one cycle after CYC; M0_DAT_o=0x12345678 with M0_ACK_o; M1_ACK_o=0.
- M0 and M1 raise CYC in the same cycle after reset -> M0 granted first. After M0 drops CYC, IDLE for 1 cycle, then Grant_o=10. Repeat the tie -> M1 then M0 order alternates.
- M1 read to an unmapped address, no slave ack, TIMEOUT_CYCLES=15 -> M1_ACK_o high exactly 15 cycles after STB with DAT=0xDEFFABAC; Timeout_o pulses once; Timeout_Cnt_o=1.
- Slave ack in the same cycle the counter reaches 1 -> slave data returned, Timeout_o stays 0, count unchanged.
- Drive 300 timeouts -> Timeout_Cnt_o saturates at 0xFF. Assert WBs_RSTn_i mid-transfer -> all outputs 0 asynchronously, count cleared.
- Build without WB_ARB_WATCHDOG_EN, unacked M0 access held for 100 cycles -> no ack, Grant_o stays 01, M1 request not granted.

Source files
------------

// File: rtl/wb_fpga_bus_arbiter.sv
// Round-robin arbiter sharing the FPGA-side Wishbone client bus between two masters.
// Define WB_ARB_WATCHDOG_EN to add the default-ack watchdog for unanswered accesses.
module wb_fpga_bus_arbiter #(
    parameter int                   ADDRWIDTH      = 17,
    parameter int                   DATAWIDTH      = 32,
    parameter int                   TIMEOUT_CYCLES = 15,
    parameter int                   CNTR_WIDTH     = 4,
    parameter logic [DATAWIDTH-1:0] DEF_RD_VALUE   = 32'hDEF_FAB_AC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RSTn_i,
    input  logic                 M0_CYC_i,
    input  logic                 M0_STB_i,
    input  logic                 M0_WE_i,
    input  logic [ADDRWIDTH-1:0] M0_ADR_i,
    input  logic [DATAWIDTH-1:0] M0_DAT_i,
    output logic                 M0_ACK_o,
    output logic [DATAWIDTH-1:0] M0_DAT_o,
    input  logic                 M1_CYC_i,
    input  logic                 M1_STB_i,
    input  logic                 M1_WE_i,
    input  logic [ADDRWIDTH-1:0] M1_ADR_i,
    input  logic [DATAWIDTH-1:0] M1_DAT_i,
    output logic                 M1_ACK_o,
    output logic [DATAWIDTH-1:0] M1_DAT_o,
    output logic                 WBs_CYC_o,
    output logic                 WBs_STB_o,
    output logic                 WBs_WE_o,
    output logic [ADDRWIDTH-1:0] WBs_ADR_o,
    output logic [DATAWIDTH-1:0] WBs_DAT_o,
    input  logic                 WBs_ACK_i,
    input  logic [DATAWIDTH-1:0] WBs_DAT_i,
    output logic [1:0]           Grant_o,
    output logic                 Timeout_o,
    output logic [7:0]           Timeout_Cnt_o,
    output logic [1:0]           dbg_state
);

    // Handshake: a master owns the bus from grant until it drops CYC; each STB phase
    // completes on the cycle its ACK is high, and STB/ACK pass through combinationally.
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, WDOG = 2'd3} state_t;

    state_t state, next_state;
    logic   last_grant;   // 1 = M1; doubles as the current owner while granted

    logic                 own_cyc, own_stb, own_we;
    logic [ADDRWIDTH-1:0] own_adr;
    logic [DATAWIDTH-1:0] own_dat;
    logic                 timeout_hit;

    assign own_cyc = last_grant ? M1_CYC_i : M0_CYC_i;
    assign own_stb = last_grant ? M1_STB_i : M0_STB_i;
    assign own_we  = last_grant ? M1_WE_i  : M0_WE_i;
    assign own_adr = last_grant ? M1_ADR_i : M0_ADR_i;
    assign own_dat = last_grant ? M1_DAT_i : M0_DAT_i;

`ifdef WB_ARB_WATCHDOG_EN
    logic [CNTR_WIDTH-1:0] wd_cnt;
    logic [7:0]            tmo_cnt;
    logic                  owning;

    assign owning      = (state == OWN0) || (state == OWN1);
    assign timeout_hit = owning && own_stb && !WBs_ACK_i && (wd_cnt == CNTR_WIDTH'(1));

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            wd_cnt  <= CNTR_WIDTH'(TIMEOUT_CYCLES);
            tmo_cnt <= 8'h00;
        end else begin
            if (owning && own_stb && !WBs_ACK_i)
                wd_cnt <= wd_cnt - CNTR_WIDTH'(1);
            else
                wd_cnt <= CNTR_WIDTH'(TIMEOUT_CYCLES);
            if (state == WDOG && tmo_cnt != 8'hFF)
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign Timeout_o     = (state == WDOG);
    assign Timeout_Cnt_o = tmo_cnt;
`else
    logic unused_ok;
    assign unused_ok     = ^{CNTR_WIDTH'(TIMEOUT_CYCLES)};
    assign timeout_hit   = 1'b0;
    assign Timeout_o     = 1'b0;
    assign Timeout_Cnt_o = 8'h00;
`endif

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE)
                last_grant <= (next_state == OWN1);
        end
    end

    always_comb begin
        next_state = state;
        WBs_CYC_o  = 1'b0;
        WBs_STB_o  = 1'b0;
        WBs_WE_o   = 1'b0;
        WBs_ADR_o  = '0;
        WBs_DAT_o  = '0;
        M0_ACK_o   = 1'b0;
        M1_ACK_o   = 1'b0;
        M0_DAT_o   = '0;
        M1_DAT_o   = '0;
        case (state)
            IDLE: begin
                if (M0_CYC_i && (!M1_CYC_i || last_grant))
                    next_state = OWN0;
                else if (M1_CYC_i)
                    next_state = OWN1;
            end
            OWN0, OWN1: begin
                WBs_CYC_o = own_cyc;
                WBs_STB_o = own_stb;
                WBs_WE_o  = own_we;
                WBs_ADR_o = own_adr;
                WBs_DAT_o = own_dat;
                if (last_grant) begin
                    M1_ACK_o = WBs_ACK_i;
                    M1_DAT_o = WBs_DAT_i;
                end else begin
                    M0_ACK_o = WBs_ACK_i;
                    M0_DAT_o = WBs_DAT_i;
                end
                if (!own_cyc)
                    next_state = IDLE;
                else if (timeout_hit)
                    next_state = WDOG;
            end
            WDOG: begin
                // Slave strobe is withdrawn and any late slave ack is deliberately dropped.
                WBs_CYC_o = own_cyc;
                WBs_WE_o  = own_we;
                WBs_ADR_o = own_adr;
                WBs_DAT_o = own_dat;
                if (last_grant) begin
                    M1_ACK_o = 1'b1;
                    M1_DAT_o = DEF_RD_VALUE;
                end else begin
                    M0_ACK_o = 1'b1;
                    M0_DAT_o = DEF_RD_VALUE;
                end
                if (!own_cyc)
                    next_state = IDLE;
                else
                    next_state = last_grant ? OWN1 : OWN0;
            end
            default: next_state = IDLE;
        endcase
    end

    assign Grant_o   = {(state == OWN1) || (state == WDOG && last_grant),
                        (state == OWN0) || (state == WDOG && !last_grant)};
    assign dbg_state = state;

endmodule
